// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-side types: RAM handshake states, word type and arbiter states.
// Also holds the load value returned when the arbiter terminates a transaction with an error.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        IBUS = 2'b01,
        DBUS = 2'b10
    } arbstate_t;

    localparam word_t ARB_BAD   = 32'hBAD1BAD1;

    // Encoding of the round-robin last-grant bit.
    localparam logic  LG_INSTR  = 1'b0;
    localparam logic  LG_DATA   = 1'b1;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Transaction watchdog for mem_arbiter: counts granted cycles and flags the last allowed one.
module mem_arb_watchdog #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_r;

    assign timeout = (count_r == CW'(TIMEOUT - 1));

    // Cycle counter; holds at the limit so it can never wrap during a stuck grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CW{1'b0}};
        end else if (clr) begin
            count_r <= {CW{1'b0}};
        end else if (en && !timeout) begin
            count_r <= count_r + CW'(1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Merges the instruction-fetch and data ports onto the single RAM request port, with watchdog.
// Build option MEM_ARB_RR_EN: alternate grants when both ports request together (default: data first).
import cpu_types_pkg::*;

module mem_arbiter #(
    parameter int    TIMEOUT = 64,
    parameter word_t BAD     = ARB_BAD
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  ramstate_t   ramstate,
    output logic        err
);

    arbstate_t state_r;
    arbstate_t next_state_s;
    logic      ram_ren_r;
    logic      ram_wen_r;
    word_t     ram_addr_r;
    word_t     ram_store_r;
    logic      err_r;

    logic      dreq_s;
    logic      bus_s;
    logic      req_s;
    logic      access_s;
    logic      fault_s;
    logic      done_s;
    logic      abort_s;
    logic      grant_d_s;
    logic      grant_i_s;
    logic      wd_timeout_s;
    word_t     load_s;

    assign dreq_s = dREN | dWEN;

    mem_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (CLK),
        .rst     (RST),
        .clr     (state_r == IDLE),
        .en      (bus_s),
        .timeout (wd_timeout_s)
    );

`ifdef MEM_ARB_RR_EN
    logic last_grant_r;

    // Remember which port won the most recent grant.
    always_ff @(posedge CLK) begin
        if (RST) begin
            last_grant_r <= LG_DATA;
        end else if (state_r == IDLE && grant_d_s) begin
            last_grant_r <= LG_DATA;
        end else if (state_r == IDLE && grant_i_s) begin
            last_grant_r <= LG_INSTR;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    // Grant selection: on a tie, the port not served last wins.
    always_comb begin
        grant_d_s = dreq_s;
        grant_i_s = iREN;
        if (dreq_s && iREN) begin
            grant_d_s = (last_grant_r == LG_INSTR);
            grant_i_s = (last_grant_r == LG_DATA);
        end else begin
            grant_d_s = dreq_s;
            grant_i_s = iREN;
        end
    end
`else
    // Grant selection: fixed data-over-instruction priority.
    always_comb begin
        grant_d_s = dreq_s;
        grant_i_s = iREN & ~dreq_s;
    end
`endif

    // Transaction status of the granted side and next-state decision.
    always_comb begin
        next_state_s = state_r;
        req_s        = 1'b0;
        bus_s        = 1'b0;
        access_s     = (ramstate == ACCESS);
        // A real ACCESS beats a timeout that lands on the same cycle.
        fault_s      = (ramstate == ERROR) || (wd_timeout_s && !access_s);
        case (state_r)
            IDLE: begin
                if (grant_d_s) begin
                    next_state_s = DBUS;
                end else if (grant_i_s) begin
                    next_state_s = IBUS;
                end else begin
                    next_state_s = IDLE;
                end
            end
            IBUS: begin
                bus_s = 1'b1;
                req_s = iREN;
            end
            DBUS: begin
                bus_s = 1'b1;
                req_s = dreq_s;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
        done_s  = bus_s && req_s && (access_s || fault_s);
        abort_s = bus_s && !req_s;
        if (done_s || abort_s) begin
            next_state_s = IDLE;
        end else begin
            next_state_s = next_state_s;
        end
    end

    assign load_s = access_s ? ramload : BAD;
    assign iwait  = iREN   & ~((state_r == IBUS) && done_s);
    assign dwait  = dreq_s & ~((state_r == DBUS) && done_s);
    assign iload  = ((state_r == IBUS) && done_s) ? load_s : 32'h0000_0000;
    assign dload  = ((state_r == DBUS) && done_s) ? load_s : 32'h0000_0000;

    // FSM state, latched RAM request (stable for the whole grant) and sticky error.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= IDLE;
            ram_ren_r   <= 1'b0;
            ram_wen_r   <= 1'b0;
            ram_addr_r  <= 32'h0000_0000;
            ram_store_r <= 32'h0000_0000;
            err_r       <= 1'b0;
        end else begin
            state_r <= next_state_s;
            err_r   <= err_r | (bus_s && fault_s);
            if (state_r == IDLE && grant_d_s) begin
                ram_ren_r   <= ~dWEN;
                ram_wen_r   <= dWEN;
                ram_addr_r  <= daddr;
                ram_store_r <= dstore;
            end else if (state_r == IDLE && grant_i_s) begin
                ram_ren_r   <= 1'b1;
                ram_wen_r   <= 1'b0;
                ram_addr_r  <= iaddr;
                ram_store_r <= ram_store_r;
            end else if (next_state_s == IDLE) begin
                ram_ren_r   <= 1'b0;
                ram_wen_r   <= 1'b0;
            end else begin
                ram_ren_r   <= ram_ren_r;
                ram_wen_r   <= ram_wen_r;
            end
        end
    end

    assign ramREN   = ram_ren_r;
    assign ramWEN   = ram_wen_r;
    assign ramaddr  = ram_addr_r;
    assign ramstore = ram_store_r;
    assign err      = err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a small latency-programmable RAM stub.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        iREN = 1'b0, dREN = 1'b0, dWEN = 1'b0;
    logic [31:0] iaddr = 32'h0, daddr = 32'h0, dstore = 32'h0;
    logic        iwait, dwait, ramREN, ramWEN, err;
    logic [31:0] iload, dload, ramaddr, ramstore, ramload;
    ramstate_t   ramstate;

    int checks = 0;
    int failures = 0;

    // RAM stub state
    int          lat = 0;
    logic        busy_mode = 1'b0;
    logic [7:0]  cnt_r = 8'd0;
    logic [31:0] mem [0:255];
    int          wr_access_cnt = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.TIMEOUT(8)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    // RAM answers ACCESS once a request has been held for lat+1 cycles
    always_comb begin
        ramstate = FREE;
        ramload  = 32'h0;
        if (ramREN || ramWEN) begin
            if (!busy_mode && int'(cnt_r) >= lat + 1) ramstate = ACCESS;
            else ramstate = BUSY;
            if (ramstate == ACCESS && ramREN) ramload = mem[ramaddr[9:2]];
        end
    end

    always @(posedge CLK) begin
        if (ramREN || ramWEN) cnt_r <= cnt_r + 8'd1;
        else cnt_r <= 8'd0;
        if (ramstate == ACCESS && ramWEN) begin
            mem[ramaddr[9:2]] <= ramstore;
            wr_access_cnt <= wr_access_cnt + 1;
        end
        if (RST) begin
            mem[8'd64]  <= 32'hDEADBEEF;   // 0x100
            mem[8'd192] <= 32'hCAFEF00D;   // 0x300
            mem[8'd32]  <= 32'hA5A5A5A5;   // 0x080
        end
    end

    task automatic cyc;
        @(posedge CLK);
        #1;
    endtask

    task automatic smp;
        @(negedge CLK);
    endtask

    task automatic test_reset;
        cyc;
        RST = 1'b1; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        cyc;
        smp;
        checks++;
        if ({ramREN, ramWEN} !== 2'b00) begin failures++; $display("FAIL reset_ren_wen got=%b exp=00", {ramREN, ramWEN}); end
        checks++;
        if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin failures++; $display("FAIL reset_addr_store got=%h/%h exp=0/0", ramaddr, ramstore); end
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++;
        if ({iwait, dwait} !== 2'b00 || iload !== 32'h0 || dload !== 32'h0) begin
            failures++; $display("FAIL reset_outputs got=%b %h %h exp=00 0 0", {iwait, dwait}, iload, dload);
        end
        cyc;
        RST = 1'b0;
        smp;
    endtask

    task automatic test_read;
        cyc;
        lat = 0; iREN = 1'b1; iaddr = 32'h0000_0100;
        smp;
        checks++;
        if (iwait !== 1'b1 || ramREN !== 1'b0) begin failures++; $display("FAIL read_idle got=%b%b exp=10", iwait, ramREN); end
        cyc; smp;
        checks++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h100 || iwait !== 1'b1) begin
            failures++; $display("FAIL read_grant got=%b %h %b exp=1 100 1", ramREN, ramaddr, iwait);
        end
        cyc; smp;
        checks++;
        if (iwait !== 1'b0 || iload !== 32'hDEADBEEF) begin failures++; $display("FAIL read_done got=%b %h exp=0 deadbeef", iwait, iload); end
        cyc;
        iREN = 1'b0;
        smp;
        checks++;
        if (ramREN !== 1'b0 || iload !== 32'h0) begin failures++; $display("FAIL read_after got=%b %h exp=0 0", ramREN, iload); end
    endtask

    task automatic test_write_readback;
        int w0;
        w0 = wr_access_cnt;
        cyc;
        dWEN = 1'b1; daddr = 32'h0000_0200; dstore = 32'h12345678;
        smp;
        cyc; smp;
        checks++;
        if ({ramWEN, ramREN} !== 2'b10 || ramstore !== 32'h12345678 || dwait !== 1'b1) begin
            failures++; $display("FAIL write_grant got=%b %h %b exp=10 12345678 1", {ramWEN, ramREN}, ramstore, dwait);
        end
        cyc; smp;
        checks++;
        if (dwait !== 1'b0 || ramWEN !== 1'b1) begin failures++; $display("FAIL write_done got=%b%b exp=01", dwait, ramWEN); end
        cyc;
        dWEN = 1'b0; dREN = 1'b1;
        smp;
        checks++;
        if (wr_access_cnt !== w0 + 1) begin failures++; $display("FAIL write_count got=%0d exp=%0d", wr_access_cnt, w0 + 1); end
        checks++;
        if (dwait !== 1'b1 || ramWEN !== 1'b0) begin failures++; $display("FAIL write_turnaround got=%b%b exp=10", dwait, ramWEN); end
        cyc; smp;
        cyc; smp;
        checks++;
        if (dwait !== 1'b0 || dload !== 32'h12345678) begin failures++; $display("FAIL readback got=%b %h exp=0 12345678", dwait, dload); end
        cyc;
        dREN = 1'b0;
        smp;
    endtask

    task automatic test_simultaneous;
        logic [3:0] seq;
        int n, nd, ni;
        seq = 4'b0000; n = 0; nd = 0; ni = 0;
        cyc;
        lat = 0; iaddr = 32'h0000_0100; daddr = 32'h0000_0300; iREN = 1'b1; dREN = 1'b1;
        for (int c = 0; c < 40 && n < 4; c++) begin
            smp;
            if (dREN && !dwait) begin
                seq[n] = 1'b1; n++; nd++;
                checks++;
                if (dload !== 32'hCAFEF00D) begin failures++; $display("FAIL sim_dload got=%h exp=cafef00d", dload); end
            end else if (iREN && !iwait) begin
                seq[n] = 1'b0; n++; ni++;
                checks++;
                if (iload !== 32'hDEADBEEF) begin failures++; $display("FAIL sim_iload got=%h exp=deadbeef", iload); end
            end
            cyc;
            if (nd == 2) dREN = 1'b0;
            if (ni == 2) iREN = 1'b0;
        end
        iREN = 1'b0; dREN = 1'b0;
        checks++;
        if (n !== 4) begin failures++; $display("FAIL sim_count got=%0d exp=4", n); end
`ifdef MEM_ARB_RR_EN
        checks++;
        if (seq[0] === seq[1] || seq[1] === seq[2] || seq[2] === seq[3]) begin
            failures++; $display("FAIL sim_order got=%b exp=alternating", seq);
        end
`else
        checks++;
        if (seq !== 4'b0011) begin failures++; $display("FAIL sim_order got=%b exp=0011 (D,D,I,I)", seq); end
`endif
        smp;
    endtask

    task automatic test_abort;
        int w0;
        w0 = wr_access_cnt;
        cyc;
        lat = 3; dWEN = 1'b1; daddr = 32'h0000_0080; dstore = 32'h11111111;
        smp;
        cyc; smp;
        checks++;
        if (ramWEN !== 1'b1) begin failures++; $display("FAIL abort_grant got=%b exp=1", ramWEN); end
        cyc;
        dWEN = 1'b0;
        smp;
        cyc; smp;
        checks++;
        if ({ramREN, ramWEN} !== 2'b00) begin failures++; $display("FAIL abort_idle got=%b exp=00", {ramREN, ramWEN}); end
        checks++;
        if (mem[8'd32] !== 32'hA5A5A5A5 || wr_access_cnt !== w0) begin
            failures++; $display("FAIL abort_mem got=%h/%0d exp=a5a5a5a5/%0d", mem[8'd32], wr_access_cnt, w0);
        end
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL abort_err got=%b exp=0", err); end
    endtask

    task automatic test_rst_mid;
        cyc;
        lat = 3; dREN = 1'b1; daddr = 32'h0000_0200;
        smp;
        cyc; smp;
        checks++;
        if (ramREN !== 1'b1) begin failures++; $display("FAIL rstmid_grant got=%b exp=1", ramREN); end
        cyc;
        RST = 1'b1;
        smp;
        cyc;
        RST = 1'b0;
        smp;
        checks++;
        if ({ramREN, ramWEN} !== 2'b00 || dwait !== 1'b1 || dload !== 32'h0) begin
            failures++; $display("FAIL rstmid_after got=%b %b %h exp=00 1 0", {ramREN, ramWEN}, dwait, dload);
        end
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL rstmid_err got=%b exp=0", err); end
        cyc;
        dREN = 1'b0;
        smp;
    endtask

    task automatic test_timeout;
        cyc;
        busy_mode = 1'b1; dREN = 1'b1; daddr = 32'h0000_0040;
        smp;
        for (int k = 1; k <= 8; k++) begin
            cyc; smp;
            if (k < 8) begin
                checks++;
                if (dwait !== 1'b1) begin failures++; $display("FAIL timeout_wait k=%0d got=%b exp=1", k, dwait); end
            end else begin
                checks++;
                if (dwait !== 1'b0 || dload !== 32'hBAD1BAD1 || err !== 1'b0) begin
                    failures++; $display("FAIL timeout_done got=%b %h %b exp=0 bad1bad1 0", dwait, dload, err);
                end
            end
        end
        cyc;
        dREN = 1'b0; busy_mode = 1'b0;
        smp;
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL timeout_err got=%b exp=1", err); end
        cyc;
        lat = 0; iREN = 1'b1; iaddr = 32'h0000_0100;
        smp;
        cyc; smp;
        cyc; smp;
        checks++;
        if (iwait !== 1'b0 || iload !== 32'hDEADBEEF) begin failures++; $display("FAIL post_timeout_read got=%b %h exp=0 deadbeef", iwait, iload); end
        cyc;
        iREN = 1'b0;
        smp;
        checks++;
        if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", err); end
    endtask

    initial begin
        test_reset;
        test_read;
        test_write_readback;
        test_simultaneous;
        test_abort;
        test_rst_mid;
        test_timeout;
        test_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
